// File: rtl/scarv_soc_dbg_bridge.sv
// ============================================================================
// Module  : scarv_soc_dbg_bridge
// Brief   : UART byte-stream debug/loader bridge issuing word reads/writes on
//           the CCX external memory interface and returning status/read data.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scarv_soc_dbg_bridge #(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] CMD_READ       = 8'h01,
  parameter logic [7:0] CMD_WRITE      = 8'h02
) (
  input  logic        f_clk,
  input  logic        g_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_RSP  = 3'd4,
    S_TX   = 3'd5
  } state_t;

  localparam int              c_TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_is_write;
  logic [1:0]      r_cnt;
  logic [c_TW-1:0] r_timer;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [7:0]      r_status;
  logic [2:0]      r_tx_idx;
  logic [2:0]      r_tx_last;
  logic            r_overrun;
  logic            w_cmd_ok;
  logic            w_rsp_fire;
  logic            w_collect;
  logic [7:0]      w_tx_data;

  assign w_cmd_ok  = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
  assign w_collect = (r_state == S_ADDR) || (r_state == S_DATA);
  // A response may complete in the grant cycle because mem_ack is already high in REQ.
  assign w_rsp_fire = mem_recv && mem_ack &&
                      (((r_state == S_REQ) && mem_gnt) || (r_state == S_RSP));

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (rx_valid) w_next = w_cmd_ok ? S_ADDR : S_TX;
      S_ADDR: begin
        if (rx_valid) begin
          if (r_cnt == 2'd3) w_next = r_is_write ? S_DATA : S_REQ;
        end else if (r_timer == c_TMAX) begin
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (r_cnt == 2'd3) w_next = S_REQ;
        end else if (r_timer == c_TMAX) begin
          w_next = S_IDLE;
        end
      end
      S_REQ: if (mem_gnt) w_next = w_rsp_fire ? S_TX : S_RSP;
      S_RSP: if (w_rsp_fire) w_next = S_TX;
      S_TX:  if (tx_ready && (r_tx_idx == r_tx_last)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      r_is_write <= 1'b0;
      r_cnt      <= 2'd0;
      r_timer    <= '0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_status   <= 8'd0;
      r_tx_idx   <= 3'd0;
      r_tx_last  <= 3'd0;
      r_overrun  <= 1'b0;
    end else begin
      if (rx_valid && !w_collect && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt    <= 2'd0;
          r_timer  <= '0;
          r_tx_idx <= 3'd0;
          if (rx_valid) begin
            r_is_write <= (rx_data == CMD_WRITE);
            if (!w_cmd_ok) begin
              r_status  <= 8'hFF;
              r_tx_last <= 3'd0;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            r_timer <= '0;
            r_cnt   <= r_cnt + 2'd1;
            // Shifting in from the top leaves the first (LS) byte in [7:0].
            if (r_state == S_ADDR) r_addr  <= {rx_data, r_addr[31:8]};
            else                   r_wdata <= {rx_data, r_wdata[31:8]};
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_REQ, S_RSP: begin
          if (w_rsp_fire) begin
            r_status  <= mem_error ? 8'h01 : 8'h00;
            r_rdata   <= mem_rdata;
            r_tx_last <= r_is_write ? 3'd0 : 3'd4;
          end
        end
        S_TX: if (tx_ready) r_tx_idx <= r_tx_idx + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tx_data = 8'h00;
    if (r_state == S_TX) begin
      case (r_tx_idx)
        3'd0:    w_tx_data = r_status;
        3'd1:    w_tx_data = r_rdata[7:0];
        3'd2:    w_tx_data = r_rdata[15:8];
        3'd3:    w_tx_data = r_rdata[23:16];
        3'd4:    w_tx_data = r_rdata[31:24];
        default: w_tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid   = (r_state == S_TX);
  assign tx_data    = w_tx_data;
  assign mem_req    = (r_state == S_REQ);
  assign mem_ack    = (r_state == S_REQ) || (r_state == S_RSP);
  assign mem_wen    = r_is_write;
  assign mem_strb   = 4'b1111;
  assign mem_addr   = r_addr & 32'hFFFF_FFFC;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign rx_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_scarv_soc_dbg_bridge.sv
// ============================================================================
// Module  : tb_scarv_soc_dbg_bridge
// Brief   : Directed + randomized bench with a transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scarv_soc_dbg_bridge;

  localparam logic [7:0] c_RD = 8'h01;
  localparam logic [7:0] c_WR = 8'h02;

  logic        f_clk, g_reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        mem_req, mem_gnt, mem_wen, mem_recv, mem_ack, mem_error;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, rx_overrun;

  scarv_soc_dbg_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .f_clk(f_clk), .g_reset(g_reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  int total = 0;
  int bad   = 0;

  // Responder configuration and observations
  int          cfg_stall, cfg_delay;
  bit          cfg_in_gnt, cfg_err;
  logic [31:0] cfg_rdata;
  int          req_count, bus_unstable, tx_unstable;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_wen;
  logic [3:0]  obs_strb;
  bit          tx_hold;
  logic [7:0]  tx_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: random grant stall, response delay, optional grant-cycle response
  initial begin
    bit aborted;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 0;
    forever begin
      @(posedge f_clk); #2;
      if (mem_req === 1'b1) begin
        req_count++;
        obs_addr = mem_addr; obs_wen = mem_wen; obs_wdata = mem_wdata; obs_strb = mem_strb;
        aborted = 0;
        for (int i = 0; i < cfg_stall; i++) begin
          @(posedge f_clk); #2;
          if (mem_req !== 1'b1) begin aborted = 1; break; end
          if (mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_wen !== obs_wen)
            bus_unstable++;
        end
        if (!aborted) begin
          mem_gnt = 1;
          if (cfg_in_gnt) begin
            mem_recv = 1; mem_error = cfg_err; mem_rdata = cfg_rdata;
          end
          @(posedge f_clk); #2;
          mem_gnt = 0;
          if (mem_req === 1'b1) bus_unstable++;
          if (cfg_in_gnt) begin
            mem_recv = 0;
          end else begin
            repeat (cfg_delay) begin @(posedge f_clk); #2; end
            mem_recv = 1; mem_error = cfg_err; mem_rdata = cfg_rdata;
            @(posedge f_clk); #2;
            mem_recv = 0;
          end
          mem_error = 0; mem_rdata = 0;
        end
      end
    end
  end

  // Transmit sink: random back-pressure, records accepted bytes, checks hold stability
  initial begin
    bit         pend;
    logic [7:0] pdata;
    pend = 0; pdata = 0; tx_ready = 0;
    forever begin
      @(negedge f_clk);
      tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      if (pend && tx_valid === 1'b1 && tx_data !== pdata) tx_unstable++;
      if (g_reset === 1'b0 && tx_valid === 1'b1 && tx_ready) tx_q.push_back(tx_data);
      pend  = (tx_valid === 1'b1) && !tx_ready;
      pdata = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge f_clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge f_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) break;
      @(posedge f_clk); #1;
    end
    check({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input bit err,
                         input int stall, input int delay, input bit in_gnt, input bit inject);
    logic [39:0] got, exp;
    cfg_stall = stall; cfg_delay = delay; cfg_in_gnt = in_gnt; cfg_err = err; cfg_rdata = rdata;
    req_count = 0; bus_unstable = 0; tx_unstable = 0; tx_q.delete();
    send_byte(wr ? c_WR : c_RD);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
    if (inject) begin
      for (int i = 0; i < 50 && mem_req !== 1'b1; i++) begin @(posedge f_clk); #1; end
      for (int i = 0; i < 50 && mem_req !== 1'b0; i++) begin @(posedge f_clk); #1; end
      send_byte(8'h55);
      check({tag, " overrun"}, rx_overrun, 1'b1);
    end
    wait_idle(tag);
    exp = '0;
    exp[7:0] = err ? 8'h01 : 8'h00;
    if (!wr) exp[39:8] = rdata;
    got = '0;
    foreach (tx_q[i]) if (i < 5) got[i*8 +: 8] = tx_q[i];
    check({tag, " reqs"},  req_count, 1);
    check({tag, " addr"},  obs_addr, {addr[31:2], 2'b00});
    check({tag, " wen"},   obs_wen, wr);
    check({tag, " strb"},  obs_strb, 4'hF);
    if (wr) check({tag, " wdata"}, obs_wdata, wdata);
    check({tag, " bus stable"}, bus_unstable, 0);
    check({tag, " tx stable"},  tx_unstable, 0);
    check({tag, " tx count"},   tx_q.size(), wr ? 1 : 5);
    check({tag, " tx bytes"},   got, exp);
  endtask

  initial begin
    g_reset = 1; rx_valid = 0; rx_data = 0; tx_hold = 0;
    cfg_stall = 0; cfg_delay = 0; cfg_in_gnt = 0; cfg_err = 0; cfg_rdata = 0;
    req_count = 0; bus_unstable = 0; tx_unstable = 0;
    repeat (3) @(posedge f_clk); #1;
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst tx_data",  tx_data, 8'h00);
    check("rst mem_req",  mem_req, 1'b0);
    check("rst mem_ack",  mem_ack, 1'b0);
    check("rst mem_wen",  mem_wen, 1'b0);
    check("rst mem_strb", mem_strb, 4'hF);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst wdata",    mem_wdata, 32'h0);
    check("rst busy",     busy, 1'b0);
    check("rst overrun",  rx_overrun, 1'b0);
    g_reset = 0;
    repeat (2) @(posedge f_clk); #1;

    run_cmd("write", 1, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 0, 1, 1, 0, 0);
    run_cmd("read",  0, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 0, 3, 2, 0, 0);
    run_cmd("err",   0, 32'h0002_0003, 32'h0, 32'h0, 1, 0, 1, 0, 0);

    // Bad command with held-off transmitter
    req_count = 0; tx_q.delete(); tx_hold = 1;
    send_byte(8'h7A);
    for (int i = 0; i < 5; i++) begin
      check("bad tx_valid", tx_valid, 1'b1);
      check("bad tx_data",  tx_data, 8'hFF);
      @(posedge f_clk); #1;
    end
    tx_hold = 0;
    wait_idle("bad");
    check("bad reqs", req_count, 0);
    check("bad tx count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("bad tx byte", tx_q[0], 8'hFF);

    // Partial command abandoned after 16 idle cycles
    req_count = 0; tx_q.delete();
    send_byte(c_WR); send_byte(8'h00); send_byte(8'h00);
    repeat (15) @(posedge f_clk); #1;
    check("timeout busy before", busy, 1'b1);
    @(posedge f_clk); #1;
    check("timeout busy after", busy, 1'b0);
    repeat (4) @(posedge f_clk); #1;
    check("timeout reqs", req_count, 0);
    check("timeout tx", tx_q.size(), 0);
    run_cmd("post-timeout read", 0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    check("overrun before", rx_overrun, 1'b0);

    run_cmd("overrun read", 0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 0, 1, 8, 0, 1);
    run_cmd("gnt-cycle rsp", 0, 32'h0000_1004, 32'h0, 32'h0BAD_CAFE, 0, 2, 0, 1, 0);

    for (int n = 0; n < 16; n++) begin
      run_cmd("rand", $urandom_range(0, 1), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 1), 0);
    end

    // Reset while a request is stalled
    cfg_stall = 20; cfg_delay = 0; cfg_in_gnt = 0; cfg_err = 0;
    send_byte(c_RD);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    for (int i = 0; i < 50 && mem_req !== 1'b1; i++) begin @(posedge f_clk); #1; end
    check("rstreq req", mem_req, 1'b1);
    check("rstreq ack", mem_ack, 1'b1);
    repeat (2) @(posedge f_clk);
    #3 g_reset = 1;
    #1;
    check("rstreq mem_req", mem_req, 1'b0);
    check("rstreq busy", busy, 1'b0);
    check("rstreq overrun", rx_overrun, 1'b0);
    repeat (2) @(posedge f_clk); #1;
    g_reset = 0;
    repeat (4) @(posedge f_clk); #1;
    run_cmd("post-reset read", 0, 32'h0003_0008, 32'h0, 32'h7654_3210, 0, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/scarv_soc_dbg_bridge.md
Name: scarv_soc_dbg_bridge

Overview:
- Host debug/loader bridge: takes a byte stream from the SoC UART receiver, decodes word read/write commands, and issues them as an initiator on the core complex external memory interface.
- Returns status and read data as a byte stream to the UART transmitter.
- Sits beside the CCX on the peripheral memory bus. Lets a host load RAM and poke MMIO without CPU involvement.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, inter-byte idle cycles mid-command before the partial command is abandoned.
- CMD_READ, 8'h01, command byte for a word read.
- CMD_WRITE, 8'h02, command byte for a word write.

Ports:
- f_clk  input  1  free-running clock; the only clock.
- g_reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- tx_valid  output  1  byte to transmit is valid.
- tx_data  output  8  byte to transmit.
- tx_ready  input  1  transmitter accepts tx_data when tx_valid&&tx_ready.
- mem_req  output  1  memory request.
- mem_gnt  input  1  request accepted when mem_req&&mem_gnt.
- mem_wen  output  1  1 = write, 0 = read.
- mem_strb  output  4  byte strobes; always 4'b1111.
- mem_addr  output  32  word address; bits [1:0] forced to 0.
- mem_wdata  output  32  write data.
- mem_recv  input  1  response valid.
- mem_ack  output  1  response accepted when mem_recv&&mem_ack.
- mem_error  input  1  response error, valid with mem_recv.
- mem_rdata  input  32  read data, valid with mem_recv.
- busy  output  1  state != IDLE.
- rx_overrun  output  1  sticky; set when a byte is dropped (rx_valid outside a collecting state). Cleared only by reset.

Behaviour:
- Reset (async, g_reset=1): state=IDLE; all outputs 0, except mem_strb=4'b1111. Byte counter, address, data and timeout counter all cleared.
- Byte ordering: all multi-byte fields are little-endian (first byte = bits [7:0]).
- IDLE:
  - rx_valid with CMD_READ or CMD_WRITE -> latch cmd, go to ADDR.
  - rx_valid with any other byte -> queue status 8'hFF, go to TX.
- ADDR: collect 4 bytes.
  - Read -> REQ.
  - Write -> DATA.
- DATA: collect 4 bytes, then REQ.
- REQ:
  - mem_req=1 with addr/wen/wdata stable until mem_req&&mem_gnt.
  - mem_req drops the cycle after the grant; next state is RSP.
  - mem_ack is held 1 from REQ entry through RSP, so a response arriving in the grant cycle is not lost.
- RSP:
  - On mem_recv&&mem_ack, capture mem_error and mem_rdata.
  - Status 8'h00 = ok, 8'h01 = error.
  - Go to TX.
- TX:
  - Emit the status byte; for a read, follow with 4 rdata bytes LE, even when the status is error.
  - tx_data/tx_valid stay stable until tx_ready.
  - Return to IDLE after the last byte is accepted.
- Timeout:
  - In ADDR/DATA the counter resets on each rx_valid.
  - On reaching TIMEOUT_CYCLES-1 with no byte, go to IDLE with no response.
  - No timeout in REQ/RSP/TX.
- Dropped bytes: rx_valid in REQ/RSP/TX sets rx_overrun and the byte is discarded.
- Latency: the first tx byte is valid no earlier than 1 cycle after the response handshake.
- Reset mid-transaction: bus signals drop immediately (async). The responder is expected to tolerate an abandoned request.

Test Plan:
- Write: rx bytes 02,00,00,01,00,EF,BE,AD,DE -> one mem_req with wen=1, addr=0x00010000, wdata=0xDEADBEEF, strb=F; responder ok -> tx 00.
- Read: rx 01,00,00,01,00; responder returns 0xDEADBEEF after 3-cycle gnt stall and 2-cycle recv delay -> addr stable throughout; tx 00,EF,BE,AD,DE.
- Error/unaligned: read of 0x00020003 with mem_error=1, rdata=0 -> mem_addr=0x00020000; tx 01,00,00,00,00.
- Bad command: rx 7A -> no mem_req; tx FF; tx_ready held low 5 cycles -> tx_data stable at FF throughout.
- Timeout: TIMEOUT_CYCLES=16; rx 02,00,00 then idle 16 cycles -> busy=0, no mem_req; a subsequent valid read completes correctly.
- Overrun/reset: rx byte during RSP -> rx_overrun=1 and no effect on the transaction; g_reset asserted during REQ -> mem_req=0 combinationally, state IDLE, rx_overrun=0.
